// File: rtl/mem_stage_if.sv
// mem_stage_if: EX->MEM payload, data-SRAM response, MEM->WB payload and the
// forwarding/interlock view of the MEM stage, bundled into one interface.
interface mem_stage_if #(
  parameter int ECODE_W = 8
);
  // flush from the CSR unit
  logic               ex_en;
  // EX -> MEM
  logic               M_allowin;
  logic               EM_valid;
  logic [31:0]        em_pc;
  logic [31:0]        em_result;
  logic               em_gr_we;
  logic [4:0]         em_dest;
  logic               em_load;
  logic [2:0]         em_ld_type;
  logic               em_ex;
  logic [ECODE_W-1:0] em_ecode;
  // data-SRAM response
  logic               data_sram_data_ok;
  logic [31:0]        data_sram_rdata;
  // MEM -> WB
  logic               W_allowin;
  logic               MW_valid;
  logic [31:0]        mw_pc;
  logic [31:0]        mw_final_result;
  logic               mw_gr_we;
  logic [4:0]         mw_dest;
  logic [31:0]        mw_vaddr;
  logic               mw_ex;
  logic [ECODE_W-1:0] mw_ecode;
  // bypass / interlock towards ID
  logic               M_fwd_valid;
  logic [4:0]         M_fwd_dest;
  logic [31:0]        M_fwd_data;
  logic               M_load_stall;

  // the MEM stage itself
  modport slave (
    input  ex_en, EM_valid, em_pc, em_result, em_gr_we, em_dest, em_load,
           em_ld_type, em_ex, em_ecode, data_sram_data_ok, data_sram_rdata, W_allowin,
    output M_allowin, MW_valid, mw_pc, mw_final_result, mw_gr_we, mw_dest, mw_vaddr,
           mw_ex, mw_ecode, M_fwd_valid, M_fwd_dest, M_fwd_data, M_load_stall
  );

  // the surrounding pipeline (EX, SRAM bridge, WB, ID)
  modport master (
    output ex_en, EM_valid, em_pc, em_result, em_gr_we, em_dest, em_load,
           em_ld_type, em_ex, em_ecode, data_sram_data_ok, data_sram_rdata, W_allowin,
    input  M_allowin, MW_valid, mw_pc, mw_final_result, mw_gr_we, mw_dest, mw_vaddr,
           mw_ex, mw_ecode, M_fwd_valid, M_fwd_dest, M_fwd_data, M_load_stall
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. Holds the EX payload, waits for the response
// of an already-issued load, aligns/extends the load data and hands the result
// to Writeback. Responses of loads killed by a flush are counted and dropped.
module mem_stage #(
  parameter int ECODE_W = 8,
  parameter int DISC_W  = 2
) (
  input  logic       clk,
  input  logic       rstn,
  mem_stage_if.slave bus
);
  localparam logic [2:0]      LD_B     = 3'd1;
  localparam logic [2:0]      LD_H     = 3'd2;
  localparam logic [2:0]      LD_BU    = 3'd3;
  localparam logic [2:0]      LD_HU    = 3'd4;
  localparam logic [DISC_W:0] DISC_MAX = {1'b0, {DISC_W{1'b1}}};
  localparam logic [DISC_W:0] DISC_ONE = {{DISC_W{1'b0}}, 1'b1};

  // stage state
  logic               m_valid_reg;
  logic [31:0]        pc_reg;
  logic [31:0]        result_reg;
  logic               gr_we_reg;
  logic [4:0]         dest_reg;
  logic               load_reg;
  logic [2:0]         ld_type_reg;
  logic               ex_reg;
  logic [ECODE_W-1:0] ecode_reg;
  logic [31:0]        rdata_buf_reg;
  logic               rdata_buf_v_reg;
  logic [DISC_W-1:0]  disc_cnt_reg;

  // combinational
  logic               resp_live;
  logic               resp_drop;
  logic               load_pending;
  logic               ready_go;
  logic               allowin;
  logic [31:0]        sel_data;
  logic [31:0]        shift_opt [4];
  logic [31:0]        aligned;
  logic [31:0]        load_data;
  logic [31:0]        final_result;
  logic               disc_inc_m;
  logic               disc_inc_e;
  logic [DISC_W:0]    disc_sum;
  logic [DISC_W-1:0]  disc_cnt_next;

  // a response belongs to the stage only when no flushed load is still owed one
  assign resp_live    = bus.data_sram_data_ok & (disc_cnt_reg == '0);
  assign resp_drop    = bus.data_sram_data_ok & (disc_cnt_reg != '0);
  assign load_pending = m_valid_reg & load_reg & ~ex_reg & ~rdata_buf_v_reg;
  assign ready_go     = ~load_pending | resp_live;
  assign allowin      = ~m_valid_reg | (ready_go & bus.W_allowin);

  // a buffered response takes precedence over whatever is on the bus now
  assign sel_data = rdata_buf_v_reg ? rdata_buf_reg : bus.data_sram_rdata;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_shift
      assign shift_opt[gi] = sel_data >> (8 * gi);
    end
  endgenerate

  assign aligned = shift_opt[result_reg[1:0]];

  // sign/zero extension by load type; word loads pass through
  always_comb begin
    load_data = aligned;
    case (ld_type_reg)
      LD_B:    load_data = {{24{aligned[7]}}, aligned[7:0]};
      LD_H:    load_data = {{16{aligned[15]}}, aligned[15:0]};
      LD_BU:   load_data = {24'b0, aligned[7:0]};
      LD_HU:   load_data = {16'b0, aligned[15:0]};
      default: load_data = aligned;
    endcase
  end

  assign final_result = (load_reg & ~ex_reg) ? load_data : result_reg;

  // outstanding responses that a flush orphans: the waiting load in MEM and a
  // load EX issued in the same cycle
  assign disc_inc_m = bus.ex_en & load_pending & ~resp_live;
  assign disc_inc_e = bus.ex_en & bus.EM_valid & bus.em_load;

  // sum all increments and the decrement, then saturate
  always_comb begin
    disc_sum = {1'b0, disc_cnt_reg};
    if (resp_drop)  disc_sum = disc_sum - DISC_ONE;
    if (disc_inc_m) disc_sum = disc_sum + DISC_ONE;
    if (disc_inc_e) disc_sum = disc_sum + DISC_ONE;
    disc_cnt_next = (disc_sum > DISC_MAX) ? DISC_MAX[DISC_W-1:0] : disc_sum[DISC_W-1:0];
  end

  // stage valid and payload capture; a flush wins over capture
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid_reg <= 1'b0;
      pc_reg      <= '0;
      result_reg  <= '0;
      gr_we_reg   <= 1'b0;
      dest_reg    <= '0;
      load_reg    <= 1'b0;
      ld_type_reg <= '0;
      ex_reg      <= 1'b0;
      ecode_reg   <= '0;
    end else if (bus.ex_en) begin
      m_valid_reg <= 1'b0;
    end else if (allowin) begin
      m_valid_reg <= bus.EM_valid;
      if (bus.EM_valid) begin
        pc_reg      <= bus.em_pc;
        result_reg  <= bus.em_result;
        gr_we_reg   <= bus.em_gr_we;
        dest_reg    <= bus.em_dest;
        load_reg    <= bus.em_load;
        ld_type_reg <= bus.em_ld_type;
        ex_reg      <= bus.em_ex;
        ecode_reg   <= bus.em_ecode;
      end
    end
  end

  // hold a live response while Writeback is stalled; drop it when the stage moves
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_buf_reg   <= '0;
      rdata_buf_v_reg <= 1'b0;
    end else if (bus.ex_en || allowin) begin
      rdata_buf_v_reg <= 1'b0;
    end else if (load_pending && resp_live) begin
      rdata_buf_reg   <= bus.data_sram_rdata;
      rdata_buf_v_reg <= 1'b1;
    end
  end

  // count of responses still owed to flushed loads
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) disc_cnt_reg <= '0;
    else       disc_cnt_reg <= disc_cnt_next;
  end

  assign bus.M_allowin       = allowin;
  assign bus.MW_valid        = m_valid_reg & ready_go;
  assign bus.mw_pc           = pc_reg;
  assign bus.mw_final_result = final_result;
  assign bus.mw_gr_we        = gr_we_reg & ~ex_reg;
  assign bus.mw_dest         = dest_reg;
  assign bus.mw_vaddr        = result_reg;
  assign bus.mw_ex           = ex_reg;
  assign bus.mw_ecode        = ecode_reg;
  assign bus.M_fwd_valid     = m_valid_reg & ready_go & gr_we_reg & ~ex_reg;
  assign bus.M_fwd_dest      = dest_reg;
  assign bus.M_fwd_data      = final_result;
  assign bus.M_load_stall    = load_pending & ~resp_live;
endmodule
